axi_sim_periph_bridge: RTL and testbench
========================================

// Module: axi_sim_periph_bridge
// PURPOSE
//  AXI4 slave-to-peripheral bridge for the verilator test top: accepts the core's AXI master traffic and
//  converts it to the simple req/gnt/rvalid peripheral bus, decoding NUM_SLV address windows (uart_sim,
//  sd_sim, ...). Supersedes the fixed 1-cycle tie-off: real handshakes, bursts, write strobes, error
//  responses and a per-beat timeout. One transaction in flight; reads and writes fairly arbitrated.
// PARAMETERS
//  ADDR_W    32                 address width
//  DATA_W    32                 data width (bytes = DATA_W/8)
//  NUM_SLV   2                  number of peripheral windows
//  SLV_BASE  {32'h9a101000,32'h9a100000}  packed NUM_SLV*ADDR_W bases, slave 0 in LSBs
//  SLV_MASK  {2{32'hffffff00}}  packed match masks; hit = (addr & mask) == base
//  TIMEOUT   255                cycles waiting for gnt or rvalid before beat aborts (8-bit counter)
// PORTS
//  clk            in   1              clock; all logic on posedge clk
//  reset          in   1              synchronous, active-low reset
//  s_awaddr/awlen/awburst/awvalid  in  ADDR_W/8/2/1   write address; s_awready out 1
//  s_wdata/wstrb/wlast/wvalid      in  DATA_W/DATA_W/8/1/1  write data; s_wready out 1
//  s_bresp out 2, s_bvalid out 1, s_bready in 1      write response
//  s_araddr/arlen/arburst/arvalid  in  ADDR_W/8/2/1   read address; s_arready out 1
//  s_rdata out DATA_W, s_rresp out 2, s_rlast out 1, s_rvalid out 1, s_rready in 1
//  p_req    out  NUM_SLV          one-hot request to selected peripheral
//  p_addr   out  ADDR_W           beat address;  p_we out 1;  p_be out DATA_W/8;  p_wdata out DATA_W
//  p_gnt    in   NUM_SLV          request accepted
//  p_rvalid in   NUM_SLV          read data valid (reads only; writes complete on gnt)
//  p_rdata  in   NUM_SLV*DATA_W   packed read data, muxed by selected slave
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all ready/valid outputs 0, p_req 0, p_we 0, resp 2'b00,
//   s_rdata 0, priority = read-first; reset mid-burst abandons the transaction, no response issued.
//  FSM: IDLE -> RADDR/WADDR (latch addr,len,burst; s_a*ready pulses 1 cycle) -> RREQ|WDATA->WREQ ->
//   RWAIT -> RRESP -> (next beat RREQ | IDLE); writes: WREQ -> next WDATA | BRESP -> IDLE.
//  Arbitration in IDLE: only one valid -> serve it; both -> serve the one not served last (toggle).
//  Decode at address latch: first matching window (lowest index) wins; no match -> unmapped.
//  p_req held with stable addr/we/be/wdata until p_gnt sampled 1; p_req drops the cycle after gnt.
//  Read beat: wait for p_rvalid after gnt (same cycle as gnt allowed); rdata registered; s_rvalid held
//   until s_rready; s_rlast=1 on beat awlen/arlen (len+1 beats). Read latency min 3 cycles AR->R.
//  Write beat: W accepted (s_wready 1 cycle) only in WDATA; p_be=wstrb; wstrb==0 -> beat skipped, no p_req.
//   s_bvalid after last beat's gnt, held until s_bready; wlast mismatch with awlen -> bresp SLVERR.
//  Burst: INCR addr += DATA_W/8 per beat, may cross window -> re-decoded each beat; FIXED keeps addr;
//   WRAP or reserved -> SLVERR on every beat, no peripheral access.
//  Unmapped: no p_req; read beats return rdata 0, rresp DECERR(2'b11); writes consume data, bresp DECERR.
//  Timeout: counter resets per beat; hits TIMEOUT -> p_req dropped, beat resp SLVERR(2'b10), rdata 0.
//  Burst response = worst of beats (DECERR > SLVERR > OKAY) for B; per-beat for R.
//  Simultaneous s_rvalid&s_rready with new p_rvalid cannot occur (one beat outstanding).
// STRUCTURE
//  Package axi_sim_pkg: state_e enum, RESP_OKAY/SLVERR/DECERR constants, burst_e (FIXED/INCR/WRAP).
//  Sub-module axi_sim_addr_dec: combinational addr -> one-hot hit[NUM_SLV] + unmapped flag.
//  Top keeps FSM, beat counter, timeout counter, response accumulate; 250-350 lines total.
// TESTING
//  Read 0x9a100004 len0, slave0 gnt+1, rvalid+2 data 0x55 -> rdata 0x55, rresp OKAY, rlast 1.
//  Write 0x9a101010 wstrb 4'b0011 data 0xdeadbeef -> p_req[1], p_be 0011, bresp OKAY after gnt.
//  Read 0x80000000 (unmapped) len3 -> 4 beats rdata 0 DECERR, rlast on 4th, p_req never asserted.
//  AR and AW valid same cycle twice -> read served first, then write, then write before read.
//  Slave0 never grants -> after 255 cycles p_req drops, rresp SLVERR; next txn proceeds normally.
//  INCR len7 write base 0x9a1000f8 -> beats 0-1 slave0, 2-7 unmapped, bresp DECERR; reset at beat 3 -> IDLE, outputs 0.

Source files
------------

// File: rtl/axi_sim_pkg.sv
// axi_sim_pkg: shared types and response codes for the AXI simulation peripheral bridge.
// Revision: 1.0
`default_nettype none

package axi_sim_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RREQ,
        ST_RWAIT,
        ST_RRESP,
        ST_WADDR,
        ST_WDATA,
        ST_WREQ,
        ST_BRESP
    } state_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Response encodings are ordered so that the numerically larger code is the worse one.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_sim_addr_dec.sv
// axi_sim_addr_dec: maps an address onto a one-hot window hit; lowest matching window wins.
// Revision: 1.0
`default_nettype none

module axi_sim_addr_dec #(
    parameter int                        ADDR_W   = 32,
    parameter int                        NUM_SLV  = 2,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h9a101000, 32'h9a100000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {2{32'hffffff00}}
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] hit,
    output logic               unmapped
);

    always_comb begin
        hit      = '0;
        unmapped = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (unmapped &&
                ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit[i]   = 1'b1;
                unmapped = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_sim_periph_bridge.sv
// axi_sim_periph_bridge: AXI4 slave to req/gnt/rvalid peripheral bus, one beat in flight.
// Revision: 1.0
`default_nettype none

module axi_sim_periph_bridge
    import axi_sim_pkg::*;
#(
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter int                        NUM_SLV  = 2,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h9a101000, 32'h9a100000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {2{32'hffffff00}},
    parameter int                        TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic [1:0]                s_awburst,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_W-1:0]         s_wdata,
    input  logic [DATA_W/8-1:0]       s_wstrb,
    input  logic                      s_wlast,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_W-1:0]         s_araddr,
    input  logic [7:0]                s_arlen,
    input  logic [1:0]                s_arburst,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [NUM_SLV-1:0]        p_req,
    output logic [ADDR_W-1:0]         p_addr,
    output logic                      p_we,
    output logic [DATA_W/8-1:0]       p_be,
    output logic [DATA_W-1:0]         p_wdata,
    input  logic [NUM_SLV-1:0]        p_gnt,
    input  logic [NUM_SLV-1:0]        p_rvalid,
    input  logic [NUM_SLV*DATA_W-1:0] p_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);

    state_e              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n, next_addr;
    logic [7:0]          len, len_n, beat, beat_n, tcnt, tcnt_n;
    logic [1:0]          burst, burst_n, rresp_q, rresp_n, resp_acc, resp_acc_n, w_acc;
    logic                prio_write, prio_n, last_beat, burst_bad, wbeat_done;
    logic [DATA_W-1:0]   rdata_q, rdata_n, wdata_q, wdata_n, sel_rdata;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_n;
    logic [NUM_SLV-1:0]  hit;
    logic                unmapped, sel_gnt, sel_rvalid;

    // Decoding the live beat address re-decodes every beat, so INCR bursts may cross windows.
    axi_sim_addr_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_dec (
        .addr     (addr),
        .hit      (hit),
        .unmapped (unmapped)
    );

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (hit[i]) sel_rdata = sel_rdata | p_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign sel_gnt    = |(p_gnt & hit);
    assign sel_rvalid = |(p_rvalid & hit);
    assign last_beat  = (beat == len);
    assign burst_bad  = (burst != BURST_FIXED) && (burst != BURST_INCR);
    assign next_addr  = (burst == BURST_FIXED) ? addr : addr + ADDR_STEP;

    assign s_rdata = rdata_q;
    assign s_rresp = rresp_q;
    assign s_bresp = resp_acc;
    assign p_addr  = addr;
    assign p_be    = wstrb_q;
    assign p_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            len        <= '0;
            burst      <= '0;
            beat       <= '0;
            tcnt       <= '0;
            prio_write <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            resp_acc   <= RESP_OKAY;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            len        <= len_n;
            burst      <= burst_n;
            beat       <= beat_n;
            tcnt       <= tcnt_n;
            prio_write <= prio_n;
            rdata_q    <= rdata_n;
            rresp_q    <= rresp_n;
            resp_acc   <= resp_acc_n;
            wdata_q    <= wdata_n;
            wstrb_q    <= wstrb_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        len_n      = len;
        burst_n    = burst;
        beat_n     = beat;
        tcnt_n     = tcnt;
        prio_n     = prio_write;
        rdata_n    = rdata_q;
        rresp_n    = rresp_q;
        resp_acc_n = resp_acc;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        s_arready  = 1'b0;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        s_rvalid   = 1'b0;
        s_rlast    = 1'b0;
        p_req      = '0;
        p_we       = 1'b0;
        wbeat_done = 1'b0;
        w_acc      = resp_acc;
        case (state)
            ST_IDLE: begin
                if (s_arvalid && s_awvalid) begin
                    prio_n  = ~prio_write;
                    state_n = prio_write ? ST_WADDR : ST_RADDR;
                end else if (s_arvalid) begin
                    state_n = ST_RADDR;
                end else if (s_awvalid) begin
                    state_n = ST_WADDR;
                end
            end
            ST_RADDR: begin
                s_arready = 1'b1;
                addr_n    = s_araddr;
                len_n     = s_arlen;
                burst_n   = s_arburst;
                beat_n    = '0;
                tcnt_n    = '0;
                state_n   = ST_RREQ;
            end
            ST_RREQ: begin
                if (burst_bad || unmapped) begin
                    rdata_n = '0;
                    rresp_n = burst_bad ? RESP_SLVERR : RESP_DECERR;
                    state_n = ST_RRESP;
                end else begin
                    p_req = hit;
                    if (sel_gnt) begin
                        tcnt_n = '0;
                        if (sel_rvalid) begin
                            rdata_n = sel_rdata;
                            rresp_n = RESP_OKAY;
                            state_n = ST_RRESP;
                        end else begin
                            state_n = ST_RWAIT;
                        end
                    end else if (tcnt == TO_LAST) begin
                        rdata_n = '0;
                        rresp_n = RESP_SLVERR;
                        state_n = ST_RRESP;
                    end else begin
                        tcnt_n = tcnt + 8'd1;
                    end
                end
            end
            ST_RWAIT: begin
                if (sel_rvalid) begin
                    rdata_n = sel_rdata;
                    rresp_n = RESP_OKAY;
                    state_n = ST_RRESP;
                end else if (tcnt == TO_LAST) begin
                    rdata_n = '0;
                    rresp_n = RESP_SLVERR;
                    state_n = ST_RRESP;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end
            ST_RRESP: begin
                s_rvalid = 1'b1;
                s_rlast  = last_beat;
                if (s_rready) begin
                    if (last_beat) begin
                        state_n = ST_IDLE;
                    end else begin
                        beat_n  = beat + 8'd1;
                        addr_n  = next_addr;
                        tcnt_n  = '0;
                        state_n = ST_RREQ;
                    end
                end
            end
            ST_WADDR: begin
                s_awready  = 1'b1;
                addr_n     = s_awaddr;
                len_n      = s_awlen;
                burst_n    = s_awburst;
                beat_n     = '0;
                resp_acc_n = RESP_OKAY;
                state_n    = ST_WDATA;
            end
            ST_WDATA: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    wdata_n = s_wdata;
                    wstrb_n = s_wstrb;
                    tcnt_n  = '0;
                    if (s_wlast != last_beat) w_acc = resp_worst(resp_acc, RESP_SLVERR);
                    resp_acc_n = w_acc;
                    if (burst_bad) begin
                        resp_acc_n = resp_worst(w_acc, RESP_SLVERR);
                        wbeat_done = 1'b1;
                    end else if (unmapped) begin
                        resp_acc_n = resp_worst(w_acc, RESP_DECERR);
                        wbeat_done = 1'b1;
                    end else if (s_wstrb == '0) begin
                        wbeat_done = 1'b1;
                    end else begin
                        state_n = ST_WREQ;
                    end
                end
            end
            ST_WREQ: begin
                p_req = hit;
                p_we  = 1'b1;
                if (sel_gnt) begin
                    wbeat_done = 1'b1;
                end else if (tcnt == TO_LAST) begin
                    resp_acc_n = resp_worst(resp_acc, RESP_SLVERR);
                    wbeat_done = 1'b1;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end
            ST_BRESP: begin
                s_bvalid = 1'b1;
                if (s_bready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (wbeat_done) begin
            if (last_beat) begin
                state_n = ST_BRESP;
            end else begin
                beat_n  = beat + 8'd1;
                addr_n  = next_addr;
                state_n = ST_WDATA;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_sim_periph_bridge.sv
// tb_axi_sim_periph_bridge: directed self-checking bench with a behavioural peripheral responder.
// Revision: 1.0
`default_nettype none

module tb_axi_sim_periph_bridge;

    localparam int LIMIT = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, p_addr, p_wdata;
    logic [7:0]  s_awlen, s_arlen;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, p_we;
    logic [3:0]  s_wstrb, p_be;
    logic [1:0]  p_req, p_gnt, p_rvalid;
    logic [63:0] p_rdata;

    axi_sim_periph_bridge u_dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .p_req(p_req), .p_addr(p_addr), .p_we(p_we), .p_be(p_be), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Peripheral responder: grants gnt_lat cycles into a request, read data rv_lat cycles after gnt.
    int          gnt_lat = 1, rv_lat = 2, req_age = 0, req_cycles = 0, wr_count = 0, rv_cnt = 0;
    bit          never_grant = 1'b0, rv_pend = 1'b0;
    logic [1:0]  rv_sel = '0, req_seen = '0, g_slv = '0;
    logic [31:0] g_addr = '0, g_wdata = '0;
    logic [3:0]  g_be = '0;

    initial begin
        p_gnt    = '0;
        p_rvalid = '0;
        p_rdata  = {32'h0000_00aa, 32'h0000_0055};
        forever begin
            @(negedge clk);
            p_gnt    = '0;
            p_rvalid = '0;
            if (!reset) begin
                rv_pend = 1'b0;
                req_age = 0;
            end else begin
                if (rv_pend) begin
                    if (rv_cnt == 0) begin
                        p_rvalid = rv_sel;
                        rv_pend  = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (p_req != '0) begin
                    req_cycles++;
                    req_seen = req_seen | p_req;
                    if (!never_grant && req_age == gnt_lat) begin
                        p_gnt   = p_req;
                        g_addr  = p_addr;
                        g_slv   = p_req;
                        g_be    = p_be;
                        g_wdata = p_wdata;
                        if (p_we) wr_count++;
                        else if (rv_lat == 0) p_rvalid = p_req;
                        else begin
                            rv_pend = 1'b1;
                            rv_cnt  = rv_lat - 1;
                            rv_sel  = p_req;
                        end
                    end
                    req_age++;
                end else begin
                    req_age = 0;
                end
            end
        end
    end

    int          order_ctr = 0, ar_order = 0, aw_order = 0, rd_n = 0;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [1:0]  wr_bresp;

    task automatic axi_rd(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        int n;
        rd_n = 0;
        s_araddr = a; s_arlen = l; s_arburst = b; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < LIMIT) begin @(negedge clk); n++; end
        if (!s_arready) begin
            check_eq("ar_handshake_timeout", 0, 1);
            s_arvalid = 1'b0;
            return;
        end
        order_ctr++;
        ar_order = order_ctr;
        @(negedge clk);
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        while (rd_n <= int'(l)) begin
            n = 0;
            while (!s_rvalid && n < LIMIT) begin @(negedge clk); n++; end
            if (!s_rvalid) begin
                check_eq("r_beat_timeout", 0, 1);
                break;
            end
            rd_data[rd_n] = s_rdata;
            rd_resp[rd_n] = s_rresp;
            rd_last[rd_n] = s_rlast;
            rd_n++;
            @(negedge clk);
        end
        s_rready = 1'b0;
    endtask

    task automatic aw_ph(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        int n;
        s_awaddr = a; s_awlen = l; s_awburst = b; s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < LIMIT) begin @(negedge clk); n++; end
        if (!s_awready) check_eq("aw_handshake_timeout", 0, 1);
        order_ctr++;
        aw_order = order_ctr;
        @(negedge clk);
        s_awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] st, input logic last);
        int n;
        s_wdata = d; s_wstrb = st; s_wlast = last; s_wvalid = 1'b1;
        n = 0;
        while (!s_wready && n < LIMIT) begin @(negedge clk); n++; end
        if (!s_wready) check_eq("w_handshake_timeout", 0, 1);
        @(negedge clk);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic b_ph();
        int n;
        s_bready = 1'b1;
        n = 0;
        while (!s_bvalid && n < LIMIT) begin @(negedge clk); n++; end
        if (!s_bvalid) check_eq("b_timeout", 0, 1);
        wr_bresp = s_bresp;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [31:0] d, input logic [3:0] st, input int last_at);
        aw_ph(a, l, b);
        for (int i = 0; i <= int'(l); i++) w_beat(d + 32'(i), st, i == last_at);
        b_ph();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {s_arready, s_awready, s_wready}, 3'b000);
        check_eq("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
        check_eq("rst_preq_we", {p_req, p_we}, 3'b000);
        check_eq("rst_resp_rdata", {s_bresp, s_rresp, s_rdata}, 36'h0);
        reset = 1'b1;
        @(negedge clk);

        axi_rd(32'h9a100004, 8'd0, 2'b01);
        check_eq("rd0_beats", rd_n, 1);
        check_eq("rd0_data", rd_data[0], 32'h55);
        check_eq("rd0_resp_last", {rd_resp[0], rd_last[0]}, {2'b00, 1'b1});
        check_eq("rd0_paddr_slave", {g_addr, g_slv}, {32'h9a100004, 2'b01});

        axi_wr(32'h9a101010, 8'd0, 2'b01, 32'hdeadbeef, 4'b0011, 0);
        check_eq("wr0_slave_be", {g_slv, g_be}, {2'b10, 4'b0011});
        check_eq("wr0_addr_data", {g_addr, g_wdata}, {32'h9a101010, 32'hdeadbeef});
        check_eq("wr0_bresp", wr_bresp, 2'b00);

        req_seen = '0;
        axi_rd(32'h80000000, 8'd3, 2'b01);
        check_eq("unm_beats", rd_n, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("unm_data_resp", {rd_data[i], rd_resp[i]}, {32'h0, 2'b11});
            check_eq("unm_rlast", rd_last[i], i == 3);
        end
        check_eq("unm_no_preq", req_seen, 2'b00);

        fork
            axi_rd(32'h9a100000, 8'd0, 2'b01);
            axi_wr(32'h9a101000, 8'd0, 2'b01, 32'h1234, 4'hf, 0);
        join
        check_eq("arb1_read_first", ar_order < aw_order, 1);
        check_eq("arb1_rdata", rd_data[0], 32'h55);
        fork
            axi_rd(32'h9a101004, 8'd0, 2'b01);
            axi_wr(32'h9a100008, 8'd0, 2'b01, 32'h5678, 4'hf, 0);
        join
        check_eq("arb2_write_first", aw_order < ar_order, 1);
        check_eq("arb2_rdata", rd_data[0], 32'haa);

        never_grant = 1'b1;
        req_cycles  = 0;
        axi_rd(32'h9a100000, 8'd0, 2'b01);
        check_eq("to_resp_data", {rd_resp[0], rd_data[0]}, {2'b10, 32'h0});
        check_eq("to_req_cycles", req_cycles, 255);
        never_grant = 1'b0;
        axi_rd(32'h9a100000, 8'd0, 2'b01);
        check_eq("after_to_rd", {rd_resp[0], rd_data[0]}, {2'b00, 32'h55});

        req_seen = '0;
        axi_rd(32'h9a100000, 8'd1, 2'b10);
        check_eq("wrap_rd", {rd_resp[0], rd_resp[1], rd_last[1]}, {2'b10, 2'b10, 1'b1});
        check_eq("wrap_no_preq", req_seen, 2'b00);

        wr_count = 0;
        axi_wr(32'h9a100000, 8'd0, 2'b01, 32'h1, 4'h0, 0);
        check_eq("zero_strb", {wr_bresp, 8'(wr_count)}, {2'b00, 8'd0});
        axi_wr(32'h9a100000, 8'd1, 2'b01, 32'h2, 4'hf, 0);
        check_eq("wlast_mismatch", {wr_bresp, 8'(wr_count)}, {2'b10, 8'd2});

        wr_count = 0;
        axi_wr(32'h9a1000f8, 8'd7, 2'b01, 32'h100, 4'hf, 7);
        check_eq("incr_cross_bresp", wr_bresp, 2'b11);
        check_eq("incr_cross_grants", wr_count, 2);
        check_eq("incr_cross_last", {g_addr, g_slv, g_wdata}, {32'h9a1000fc, 2'b01, 32'h101});

        aw_ph(32'h9a1000f8, 8'd7, 2'b01);
        for (int i = 0; i < 3; i++) w_beat(32'h200 + 32'(i), 4'hf, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", {s_awready, s_wready, s_arready}, 3'b000);
        check_eq("midrst_out", {s_bvalid, s_rvalid, p_req, p_we, s_bresp}, 7'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_no_bvalid", s_bvalid, 1'b0);
        axi_rd(32'h9a101000, 8'd0, 2'b01);
        check_eq("midrst_recover", {rd_resp[0], rd_data[0]}, {2'b00, 32'haa});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
